// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcodes and the
// operand bundle latched into the execute stage.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0100;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } s1_t;

endpackage

// File: rtl/alu.sv
// Shared 32-bit integer ALU; unknown opcodes add.
// Arithmetic is modular, carry and overflow dropped.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = a + b;
    unique case (1'b1)
      (op == OP_SUB): y = a - b;
      (op == OP_AND): y = a & b;
      (op == OP_OR):  y = a | b;
      (op == OP_XOR): y = a ^ b;
      default:        y = a + b;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid
// index at or after ptr, wrapping, as one-hot + index.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic found;

  // Two passes: upper segment from ptr, then the wrap.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i] && i >= int'(ptr)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i] && i < int'(ptr)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NREQ requesters: round-robin
// grant, operand register, tagged response register.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*OP_W-1:0]   req_op,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_zero
);

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gidx;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    ptr_nxt;
  logic              xfer;
  s1_t               sel;
  s1_t               s1;
  logic [IDW-1:0]    s1_id;
  logic              s1_valid;
  logic [NREQ-1:0]   s1_oh;
  logic [DATA_W-1:0] y;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .valid(req_valid),
    .ptr  (ptr),
    .gnt  (gnt),
    .idx  (gidx)
  );

  assign req_ready = (stall || reset) ? '0 : gnt;
  assign xfer      = |req_ready;

  assign ptr_nxt = (int'(gidx) == NREQ - 1)
                 ? '0 : gidx + 1'b1;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel.a  = req_a[i*DATA_W +: DATA_W];
        sel.b  = req_b[i*DATA_W +: DATA_W];
        sel.op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      s1       <= '0;
      s1_id    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        ptr   <= ptr_nxt;
        s1    <= sel;
        s1_id <= gidx;
      end
    end
  end

  alu u_alu (
    .a (s1.a),
    .b (s1.b),
    .op(s1.op),
    .y (y)
  );

  assign s1_oh = NREQ'(1) << s1_id;

  // Payload holds between pulses; only rsp_valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      rsp_valid <= s1_valid ? s1_oh : '0;
      if (s1_valid) begin
        rsp_id     <= s1_id;
        rsp_result <= y;
        rsp_zero   <= (y == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Table-driven bench with a response scoreboard
// for the two-requester shared ALU arbiter.
module tb_alu_share_arbiter;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          clr;
    logic [1:0]  v;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  op0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [3:0]  op1;
    logic [1:0]  rdy;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [7:0]  req_op = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tv[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NREQ(2),
    .IDW (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero)
  );

  function automatic vec_t mk(
    bit rst, bit st, bit clr, logic [1:0] v,
    logic [31:0] a0, logic [31:0] b0, logic [3:0] op0,
    logic [31:0] a1, logic [31:0] b1, logic [3:0] op1,
    logic [1:0] rdy, logic [31:0] res);
    vec_t t;
    t.rst = rst;  t.stall = st; t.clr = clr;
    t.v   = v;
    t.a0  = a0;   t.b0 = b0;    t.op0 = op0;
    t.a1  = a1;   t.b1 = b1;    t.op1 = op1;
    t.rdy = rdy;  t.res = res;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  initial begin
    int g0, g1;
    exp_t e;
    g0 = 0;
    g1 = 0;

    // rst st clr v  a0 b0 op0  a1 b1 op1  rdy res
    tv.push_back(mk(1,0,0,2'b11, 1,1,0, 2,2,0, 2'b00, 0));
    tv.push_back(mk(0,0,1,2'b01, 10,20,4'h0,
                    0,0,0, 2'b01, 32'h1E));
    tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0));
    tv.push_back(mk(0,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0));
    tv.push_back(mk(1,0,0,2'b00, 0,0,0, 0,0,0, 2'b00, 0));
    tv.push_back(mk(0,0,1,2'b11, 50,30,4'h1,
                    5,3,4'h2, 2'b01, 32'h14));
    tv.push_back(mk(0,0,0,2'b10, 0,0,0,
                    5,3,4'h2, 2'b10, 32'h1));
    for (int k = 0; k < 8; k++) begin
      tv.push_back(mk(0,0,0,2'b11,
        100 + k, k, 4'h0, 32'hF0, k, 4'h3,
        (k % 2 == 0) ? 2'b01 : 2'b10,
        (k % 2 == 0) ? 32'(100 + 2*k)
                     : (32'hF0 | 32'(k))));
    end
    tv.push_back(mk(0,0,0,2'b01, 7,7,4'h1,
                    0,0,0, 2'b01, 32'h0));
    tv.push_back(mk(0,0,0,2'b01, 15,25,4'hF,
                    0,0,0, 2'b01, 32'h28));
    tv.push_back(mk(0,0,0,2'b01, 3,4,4'h0,
                    0,0,0, 2'b01, 32'h7));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0,1,0,2'b10, 0,0,0,
                      9,6,4'h1, 2'b00, 0));
    tv.push_back(mk(0,0,0,2'b10, 0,0,0,
                    9,6,4'h1, 2'b10, 32'h3));
    tv.push_back(mk(0,0,0,2'b01, 7,2,4'h4,
                    0,0,0, 2'b01, 32'h5));
    tv.push_back(mk(1,0,0,2'b11, 1,1,4'h2,
                    8,8,4'h0, 2'b00, 0));
    tv.push_back(mk(0,0,1,2'b11, 1,1,4'h2,
                    8,8,4'h0, 2'b01, 32'h1));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0,0,0,2'b00, 0,0,0,
                      0,0,0, 2'b00, 0));

    for (int r = 0; r < tv.size(); r++) begin
      @(posedge clk);
      #1;
      reset     = tv[r].rst;
      stall     = tv[r].stall;
      req_valid = tv[r].v;
      req_a     = {tv[r].a1, tv[r].a0};
      req_b     = {tv[r].b1, tv[r].b0};
      req_op    = {tv[r].op1, tv[r].op0};
      @(negedge clk);

      chk($sformatf("ready[%0d]", r),
          64'(req_ready), 64'(tv[r].rdy));
      if (r >= 7 && r < 15) begin
        g0 += int'(req_ready[0]);
        g1 += int'(req_ready[1]);
      end

      if (tv[r].rdy != 2'b00) begin
        e.due  = r + 2;
        e.id   = (tv[r].rdy == 2'b10) ? 2'd1 : 2'd0;
        e.res  = tv[r].res;
        e.zero = (tv[r].res == 32'h0);
        sb.push_back(e);
      end

      if (sb.size() > 0 && sb[0].due == r) begin
        e = sb.pop_front();
        chk($sformatf("rsp_valid[%0d]", r),
            64'(rsp_valid), 64'(2'b01 << e.id));
        chk($sformatf("rsp_id[%0d]", r),
            64'(rsp_id), 64'(e.id));
        chk($sformatf("rsp_result[%0d]", r),
            64'(rsp_result), 64'(e.res));
        chk($sformatf("rsp_zero[%0d]", r),
            64'(rsp_zero), 64'(e.zero));
      end else begin
        chk($sformatf("rsp_idle[%0d]", r),
            64'(rsp_valid), 64'(0));
      end

      if (tv[r].clr)
        chk($sformatf("rsp_clr[%0d]", r),
            {29'(0), rsp_zero, rsp_id, rsp_result},
            64'(0));

      // Reset drops everything not yet in the rsp register.
      if (tv[r].rst)
        while (sb.size() > 0 && sb[$].due > r)
          void'(sb.pop_back());
    end

    chk("fair_g0", 64'(g0), 64'(4));
    chk("fair_g1", 64'(g1), 64'(4));
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
